pkt_split: RTL and testbench

//  Packet demultiplexer: the inverse of the two-input packet merge. Accepts one

---
 rtl/pkt_split.sv | 158 +++++++++++++++
 tb/tb_pkt_split.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_split.sv
// Packet demultiplexer: routes whole packets from one put port to one of two
// FIFO-buffered get ports, using the DEST bit of each SOP beat.
module pkt_split #(
  parameter int WIDTH = 153,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] iport_put,
  input  logic             EN_iport_put,
  output logic             RDY_iport_put,
  input  logic             EN_oport0_get,
  output logic [WIDTH-1:0] oport0_get,
  output logic             RDY_oport0_get,
  input  logic             EN_oport1_get,
  output logic [WIDTH-1:0] oport1_get,
  output logic             RDY_oport1_get,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             route_r, route_nxt_s;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [WIDTH-1:0] mem_r    [2][DEPTH];
  logic [AW-1:0]    wr_ptr_r [2];
  logic [AW-1:0]    rd_ptr_r [2];
  logic [AW:0]      cnt_r    [2];

  logic [1:0] full_s, pop_s, wr_s;
  logic       rdy_put_s, accept_s, drop_s;
  logic       sop_s, eop_s, dest_s;

  assign sop_s  = iport_put[WIDTH-1];
  assign eop_s  = iport_put[WIDTH-2];
  assign dest_s = iport_put[WIDTH-3];

  // FIFO status and pop qualification
  always_comb begin
    full_s[0] = (cnt_r[0] == CNT_FULL);
    full_s[1] = (cnt_r[1] == CNT_FULL);
    pop_s[0]  = EN_oport0_get & (cnt_r[0] != CNT_ZERO);
    pop_s[1]  = EN_oport1_get & (cnt_r[1] != CNT_ZERO);
  end

  // Put readiness: in IDLE the destination is unknown, so both FIFOs need room
  always_comb begin
    rdy_put_s = 1'b0;
    case (state_r)
      ST_IDLE: rdy_put_s = ~full_s[0] & ~full_s[1];
      ST_PKT:  rdy_put_s = ~full_s[route_r];
      default: rdy_put_s = 1'b0;
    endcase
  end

  assign accept_s = EN_iport_put & rdy_put_s;

  // Next-state, routing and write/drop decode
  always_comb begin
    state_nxt_s = state_r;
    route_nxt_s = route_r;
    wr_s        = 2'b00;
    drop_s      = 1'b0;
    if (accept_s) begin
      if (sop_s) begin
        // An SOP in PKT to the non-routed FIFO is not covered by RDY, so it may hit a full FIFO
        if (full_s[dest_s]) begin
          drop_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          wr_s[dest_s] = 1'b1;
          route_nxt_s  = dest_s;
          state_nxt_s  = eop_s ? ST_IDLE : ST_PKT;
        end
      end else begin
        case (state_r)
          ST_PKT: begin
            wr_s[route_r] = 1'b1;
            state_nxt_s   = eop_s ? ST_IDLE : ST_PKT;
          end
          ST_IDLE: drop_s = 1'b1;
          default: begin
            drop_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM, route and saturating drop counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      route_r    <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      route_r <= route_nxt_s;
      if (drop_s && (drop_cnt_r != DROP_MAX)) begin
        drop_cnt_r <= drop_cnt_r + DROP_ONE;
      end
    end
  end

  // Two output FIFOs; storage is cleared on reset so heads read zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_r[i] <= PTR_ZERO;
        rd_ptr_r[i] <= PTR_ZERO;
        cnt_r[i]    <= CNT_ZERO;
        for (int j = 0; j < DEPTH; j++) begin
          mem_r[i][j] <= {WIDTH{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= iport_put;
          wr_ptr_r[i]           <= wr_ptr_r[i] + PTR_ONE;
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        end
        if (wr_s[i] && !pop_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (!wr_s[i] && pop_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end
      end
    end
  end

  assign RDY_iport_put  = rdy_put_s;
  assign oport0_get     = mem_r[0][rd_ptr_r[0]];
  assign oport1_get     = mem_r[1][rd_ptr_r[1]];
  assign RDY_oport0_get = (cnt_r[0] != CNT_ZERO);
  assign RDY_oport1_get = (cnt_r[1] != CNT_ZERO);
  assign drop_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_pkt_split.sv
// Directed and randomized bench for pkt_split, checked against a queue-based
// packet-routing model.
module tb_pkt_split;
  localparam int W = 153;
  localparam int D = 4;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] put = '0;
  logic         en_put = 1'b0;
  logic         rdy_put;
  logic         en0 = 1'b0, en1 = 1'b0;
  logic [W-1:0] get0, get1;
  logic         rdy0, rdy1;
  logic [C-1:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           m_open = 1'b0;
  bit           m_route = 1'b0;
  int           m_drop = 0;

  always #5 clk = ~clk;

  pkt_split #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .CLK(clk), .RST_N(rst_n),
    .iport_put(put), .EN_iport_put(en_put), .RDY_iport_put(rdy_put),
    .EN_oport0_get(en0), .oport0_get(get0), .RDY_oport0_get(rdy0),
    .EN_oport1_get(en1), .oport1_get(get1), .RDY_oport1_get(rdy1),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [W-1:0] mk(input bit sop, input bit eop, input bit dest);
    logic [159:0] r;
    for (int k = 0; k < 5; k++) r[k*32 +: 32] = $urandom;
    r[W-1] = sop;
    r[W-2] = eop;
    r[W-3] = dest;
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_open = 1'b0;
    m_route = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_drop();
    if (m_drop < 65535) m_drop++;
    m_open = 1'b0;
  endtask

  // Drive one cycle, compare DUT against the model, then advance the model
  task automatic cyc(input bit en, input logic [W-1:0] b, input bit p0, input bit p1);
    bit f0, f1, rdy, sop, eop, dst;
    en_put = en; put = b; en0 = p0; en1 = p1;
    #1;
    f0 = (q0.size() >= D);
    f1 = (q1.size() >= D);
    rdy = m_open ? (m_route ? !f1 : !f0) : (!f0 && !f1);
    chk("rdy_put", W'(rdy_put), W'(rdy));
    chk("rdy0", W'(rdy0), W'(q0.size() != 0));
    chk("rdy1", W'(rdy1), W'(q1.size() != 0));
    if (q0.size() != 0) chk("data0", get0, q0[0]);
    if (q1.size() != 0) chk("data1", get1, q1[0]);
    chk("drop_cnt", W'(drop_cnt), W'(m_drop));
    if (p0 && q0.size() != 0) void'(q0.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    if (en && rdy) begin
      sop = b[W-1]; eop = b[W-2]; dst = b[W-3];
      if (sop) begin
        if (dst ? f1 : f0) model_drop();
        else begin
          if (dst) q1.push_back(b); else q0.push_back(b);
          m_route = dst;
          m_open = !eop;
        end
      end else if (m_open) begin
        if (m_route) q1.push_back(b); else q0.push_back(b);
        m_open = !eop;
      end else begin
        model_drop();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2*D + 2; k++) cyc(1'b0, '0, 1'b1, 1'b1);
    chk("drained0", W'(rdy0), W'(0));
    chk("drained1", W'(rdy1), W'(0));
  endtask

  initial begin
    bit d;
    bit sop;
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy_put", W'(rdy_put), W'(1));
    chk("rst_rdy0", W'(rdy0), W'(0));
    chk("rst_rdy1", W'(rdy1), W'(0));
    chk("rst_get0", get0, W'(0));
    chk("rst_get1", get1, W'(0));
    chk("rst_drop", W'(drop_cnt), W'(0));
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // 2: three-beat packet to port 1, then a non-SOP beat proves IDLE
    cyc(1'b1, mk(1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
    chk("t2_rdy1_next", W'(rdy1), W'(1));
    cyc(1'b1, mk(1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t2_rdy0_empty", W'(rdy0), W'(0));
    cyc(1'b1, mk(1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    chk("t2_drop", W'(drop_cnt), W'(1));
    drain();

    // 3: single-beat packet, stray beat, then overfill port 0
    cyc(1'b1, mk(1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t3_drop", W'(drop_cnt), W'(2));
    drain();
    cyc(1'b1, mk(1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 1; k <= D; k++) cyc(1'b1, mk(1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("t3_full_block", W'(rdy_put), W'(0));
    cyc(1'b1, mk(1'b0, 1'b1, 1'b0), 1'b1, 1'b0);
    cyc(1'b1, mk(1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
    drain();

    // 4: streaming with a pop every cycle on port 0
    for (int k = 0; k < 10; k++) cyc(1'b1, mk(k == 0, k == 9, 1'b0), 1'b1, 1'b0);
    drain();

    // 5: reset mid-packet with two beats in FIFO 1
    cyc(1'b1, mk(1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
    cyc(1'b1, mk(1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    en_put = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rdy1_async", W'(rdy1), W'(0));
    chk("t5_rdy_put", W'(rdy_put), W'(1));
    chk("t5_drop_rst", W'(drop_cnt), W'(0));
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, mk(1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_drop", W'(drop_cnt), W'(1));

    // 6: alternating-destination packets with random pops and occasional truncation
    d = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sop = !m_open || ($urandom_range(0, 15) == 0);
      cyc($urandom_range(0, 3) != 0,
          mk(sop, $urandom_range(0, 2) == 0, sop ? d : bit'($urandom_range(0, 1))),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      if (sop && m_open) d = ~d;
      else if (sop && !m_open && m_route == d) d = ~d;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
